// File: rtl/pikarisc_pkg.sv
// PikaRISC shared definitions: opcodes, instruction formats and field positions.
// Used by both the instruction encoder/loader and the decode stage.
package pikarisc_pkg;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_CR, FMT_CI, FMT_J, FMT_M, FMT_CALL, FMT_RET, FMT_ILL
  } fmt_e;

  localparam logic [5:0] OP_ADDrr     = 6'h08;
  localparam logic [5:0] OP_NOTr      = 6'h0A;
  localparam logic [5:0] OP_NOTi      = 6'h0B;
  localparam logic [5:0] OP_ANDri     = 6'h11;
  localparam logic [5:0] OP_MOVriLO16 = 6'h13;
  localparam logic [5:0] OP_MOVriHI16 = 6'h15;
  localparam logic [5:0] OP_CMPrr     = 6'h20;
  localparam logic [5:0] OP_CMPri     = 6'h21;
  localparam logic [5:0] OP_JEQ       = 6'h23;
  localparam logic [5:0] OP_LD        = 6'h24;
  localparam logic [5:0] OP_STR       = 6'h25;
  localparam logic [5:0] OP_CALL      = 6'h26;
  localparam logic [5:0] OP_RET       = 6'h27;

  localparam int OPC_LSB  = 26;
  localparam int RD_LSB   = 22;
  localparam int COND_LSB = 22;
  localparam int RS_LSB   = 18;
  localparam int RT_LSB   = 14;
  localparam int IMM_W    = 18;
  localparam int MEM_W    = 22;

  function automatic fmt_e fmt_of(input logic [5:0] op);
    fmt_e f;
    f = FMT_ILL;
    if (!op[5]) begin
      f = op[0] ? FMT_I : FMT_R;
    end else if (!op[4]) begin
      // 101xxx is unassigned and treated the same as 11xxxx
      case (op[3:1])
        3'b000:  f = op[0] ? FMT_CI : FMT_CR;
        3'b001:  f = FMT_J;
        3'b010:  f = FMT_M;
        3'b011:  f = op[0] ? FMT_RET : FMT_CALL;
        default: f = FMT_ILL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; head entry is visible on rdata_o without a pop.
// The caller never pushes when full nor pops when empty.
module sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes PikaRISC field tuples into 32-bit words, buffers them and streams
// them into instruction memory at sequential addresses.
module instr_encode_loader
  import pikarisc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [3:0]        in_cond,
  input  logic [17:0]       in_imm,
  input  logic [21:0]       in_mem,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  function automatic logic [31:0] encode(
    input logic [5:0]  op,
    input logic [3:0]  rd, rs, rt, cond,
    input logic [17:0] imm,
    input logic [21:0] mem
  );
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6] = op;
    case (fmt_of(op))
      FMT_R:    begin w[RD_LSB +: 4] = rd; w[RS_LSB +: 4] = rs; w[RT_LSB +: 4] = rt; end
      FMT_I:    begin w[RD_LSB +: 4] = rd; w[RS_LSB +: 4] = rs; w[0 +: IMM_W] = imm; end
      FMT_CR:   begin w[RS_LSB +: 4] = rs; w[RT_LSB +: 4] = rt; end
      FMT_CI:   begin w[RS_LSB +: 4] = rs; w[0 +: IMM_W] = imm; end
      FMT_J:    begin w[COND_LSB +: 4] = cond; w[0 +: MEM_W] = mem; end
      FMT_M:    begin w[RD_LSB +: 4] = rd; w[0 +: MEM_W] = mem; end
      FMT_CALL: w[0 +: MEM_W] = mem;
      default:  ;
    endcase
    return w;
  endfunction

  state_e            state_q;
  logic              in_ready_q, err_q, pend_q, wc_clr_q;
  logic [ADDR_W-1:0] addr_q, wc_q;
  logic [32:0]       head;
  logic [CW-1:0]     count, cnt_d;
  logic              illegal_in, acc, push, hs, empty, drain_done;

  assign illegal_in = (fmt_of(in_opcode) == FMT_ILL);
  assign acc        = in_valid && in_ready_q;
  assign push       = acc && !illegal_in;
  assign empty      = (count == '0);
  assign imem_we    = !empty && (state_q != S_DONE);
  assign hs         = imem_we && imem_ready;
  assign cnt_d      = count + CW'(push) - CW'(hs);
  // An illegal last tuple finishes the program once everything ahead of it is written
  assign drain_done = pend_q && empty && (state_q != S_DONE);

  sync_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (hs),
    .wdata_i ({in_last, encode(in_opcode, in_rd, in_rs, in_rt, in_cond, in_imm, in_mem)}),
    .rdata_o (head),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      wc_clr_q   <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      wc_q       <= '0;
    end else begin
      in_ready_q <= (cnt_d != CW'(FIFO_DEPTH));
      if (acc && illegal_in) err_q <= 1'b1;
      if (drain_done) pend_q <= 1'b0;
      if (acc && illegal_in && in_last) pend_q <= 1'b1;
      if (hs) begin
        addr_q   <= addr_q + 1'b1;
        wc_q     <= wc_clr_q ? ADDR_W'(1) : wc_q + 1'b1;
        wc_clr_q <= 1'b0;
      end
      case (state_q)
        S_DONE: state_q <= (cnt_d != '0) ? S_WRITE : S_IDLE;
        default: begin
          if ((hs && head[32]) || drain_done) begin
            state_q  <= S_DONE;
            addr_q   <= ADDR_W'(BASE_ADDR);
            wc_clr_q <= 1'b1;
          end else begin
            state_q <= (cnt_d != '0) ? S_WRITE : S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = imem_we ? head[31:0] : 32'h0;
  assign done        = (state_q == S_DONE);
  assign err_illegal = err_q;
  assign word_count  = wc_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encoding, masking, sequencing,
// backpressure, illegal opcodes and asynchronous reset.
module tb_instr_encode_loader;
  import pikarisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [5:0]  in_opcode;
  logic [3:0]  in_rd, in_rs, in_rt, in_cond;
  logic [17:0] in_imm;
  logic [21:0] in_mem;
  logic        imem_we, imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        done, err_illegal;
  logic [9:0]  word_count;

  int checks = 0;
  int errors = 0;

  instr_encode_loader #(.FIFO_DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond),
    .in_imm(in_imm), .in_mem(in_mem), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] cond, input logic [17:0] imm,
                       input logic [21:0] mem, input logic last);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_cond = cond; in_imm = imm; in_mem = mem; in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; in_opcode = '0; in_rd = '0; in_rs = '0;
    in_rt = '0; in_cond = '0; in_imm = '0; in_mem = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    imem_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    imem_ready = 1'b1;
    repeat (2) step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    checks++; if ({done, err_illegal} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {done, err_illegal}); end
    checks++; if (word_count !== 10'd0) begin errors++; $display("FAIL rst_wc got %0d want 0", word_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addrr();
    do_reset();
    drive(OP_ADDrr, 4'd2, 4'd3, 4'd4, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b0);
    step();
    idle_in();
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", imem_we); end
    checks++; if (imem_wdata !== 32'h208D0000) begin errors++; $display("FAIL add_wdata got %h want 208d0000", imem_wdata); end
    checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL add_addr got %0d want 0", imem_addr); end
    step();
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL add_we_after got %b want 0", imem_we); end
    checks++; if (imem_addr !== 10'd1 || word_count !== 10'd1) begin errors++; $display("FAIL add_cnt got addr %0d wc %0d want 1 1", imem_addr, word_count); end
  endtask

  task automatic test_andri_cmprr();
    do_reset();
    drive(OP_ANDri, 4'd5, 4'd6, 4'hF, 4'hF, 18'h7, 22'h3FFFFF, 1'b0);
    step();
    drive(OP_CMPrr, 4'hF, 4'd8, 4'd9, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b0);
    checks++; if (imem_wdata !== 32'h45580007 || imem_addr !== 10'd0) begin errors++; $display("FAIL andri got %h@%0d want 45580007@0", imem_wdata, imem_addr); end
    step();
    idle_in();
    checks++; if (imem_wdata !== 32'h80224000 || imem_addr !== 10'd1) begin errors++; $display("FAIL cmprr got %h@%0d want 80224000@1", imem_wdata, imem_addr); end
    step();
    checks++; if (imem_we !== 1'b0 || word_count !== 10'd2) begin errors++; $display("FAIL andcmp_end got we %b wc %0d want 0 2", imem_we, word_count); end
  endtask

  task automatic test_program_done();
    do_reset();
    drive(OP_JEQ, 4'hF, 4'hF, 4'hF, 4'd1, 18'h3FFFF, 22'hA, 1'b0);
    step();
    drive(OP_LD, 4'd11, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'hC, 1'b0);
    checks++; if (imem_wdata !== 32'h8C40000A || imem_addr !== 10'd0) begin errors++; $display("FAIL jeq got %h@%0d want 8c40000a@0", imem_wdata, imem_addr); end
    step();
    drive(OP_RET, 4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b1);
    checks++; if (imem_wdata !== 32'h92C0000C || imem_addr !== 10'd1) begin errors++; $display("FAIL ld got %h@%0d want 92c0000c@1", imem_wdata, imem_addr); end
    step();
    idle_in();
    checks++; if (imem_wdata !== 32'h9C000000 || imem_addr !== 10'd2 || done !== 1'b0) begin errors++; $display("FAIL ret got %h@%0d done %b want 9c000000@2 0", imem_wdata, imem_addr, done); end
    step();
    checks++; if (done !== 1'b1 || imem_we !== 1'b0) begin errors++; $display("FAIL prog_done got done %b we %b want 1 0", done, imem_we); end
    checks++; if (imem_addr !== 10'd0 || word_count !== 10'd3) begin errors++; $display("FAIL prog_done_addr got addr %0d wc %0d want 0 3", imem_addr, word_count); end
    step();
    drive(OP_ADDrr, 4'd2, 4'd3, 4'd4, 4'h0, 18'h0, 22'h0, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
    step();
    idle_in();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL next_prog got we %b addr %0d want 1 0", imem_we, imem_addr); end
    step();
    checks++; if (word_count !== 10'd1 || imem_addr !== 10'd1) begin errors++; $display("FAIL wc_clear got wc %0d addr %0d want 1 1", word_count, imem_addr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h20048000; exp_w[1] = 32'h20448000;
    exp_w[2] = 32'h20848000; exp_w[3] = 32'h20C48000;
    do_reset();
    imem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(OP_ADDrr, 4'(k), 4'd1, 4'd2, 4'h0, 18'h0, 22'h0, 1'b0);
      step();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    checks++; if (imem_we !== 1'b1 || imem_wdata !== exp_w[0] || imem_addr !== 10'd0) begin errors++; $display("FAIL bp_hold got we %b %h@%0d want 1 %h@0", imem_we, imem_wdata, imem_addr, exp_w[0]); end
    idle_in();
    imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_we !== 1'b1 || imem_wdata !== exp_w[k] || imem_addr !== 10'(k)) begin errors++; $display("FAIL bp_drain%0d got we %b %h@%0d want 1 %h@%0d", k, imem_we, imem_wdata, imem_addr, exp_w[k], k); end
      step();
    end
    checks++; if (imem_we !== 1'b0 || word_count !== 10'd4) begin errors++; $display("FAIL bp_end got we %b wc %0d want 0 4", imem_we, word_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h840D2345; exp_w[1] = 32'h983FFFFF;
    exp_w[2] = 32'h95D55555; exp_w[3] = 32'h5443FFFF;
    do_reset();
    drive(OP_CMPri, 4'hF, 4'd3, 4'hF, 4'hF, 18'h12345, 22'h3FFFFF, 1'b0);
    step();
    drive(OP_CALL, 4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b0);
    checks++; if (imem_wdata !== exp_w[0]) begin errors++; $display("FAIL cmpri got %h want %h", imem_wdata, exp_w[0]); end
    step();
    drive(OP_STR, 4'd7, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h155555, 1'b0);
    checks++; if (imem_wdata !== exp_w[1] || imem_addr !== 10'd1) begin errors++; $display("FAIL call got %h@%0d want %h@1", imem_wdata, imem_addr, exp_w[1]); end
    step();
    drive(OP_MOVriHI16, 4'd1, 4'd0, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b0);
    checks++; if (imem_wdata !== exp_w[2] || imem_addr !== 10'd2) begin errors++; $display("FAIL str got %h@%0d want %h@2", imem_wdata, imem_addr, exp_w[2]); end
    step();
    idle_in();
    checks++; if (imem_wdata !== exp_w[3] || imem_addr !== 10'd3) begin errors++; $display("FAIL movhi got %h@%0d want %h@3", imem_wdata, imem_addr, exp_w[3]); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(OP_ANDri, 4'd5, 4'd6, 4'h0, 4'h0, 18'h7, 22'h0, 1'b0);
    step();
    drive(6'h30, 4'd1, 4'd1, 4'd1, 4'd1, 18'h1, 22'h1, 1'b1);
    checks++; if (imem_wdata !== 32'h45580007) begin errors++; $display("FAIL ill_prior got %h want 45580007", imem_wdata); end
    step();
    idle_in();
    checks++; if (imem_we !== 1'b0 || err_illegal !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ill_drop got we %b err %b done %b want 0 1 0", imem_we, err_illegal, done); end
    step();
    checks++; if (done !== 1'b1 || word_count !== 10'd1) begin errors++; $display("FAIL ill_done got done %b wc %0d want 1 1", done, word_count); end
    step();
    checks++; if (done !== 1'b0 || err_illegal !== 1'b1 || imem_we !== 1'b0) begin errors++; $display("FAIL ill_sticky got done %b err %b we %b want 0 1 0", done, err_illegal, imem_we); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b0;
    drive(6'h3F, 4'd0, 4'd0, 4'd0, 4'd0, 18'h0, 22'h0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(OP_ADDrr, 4'(k), 4'd1, 4'd2, 4'h0, 18'h0, 22'h0, 1'b0);
      step();
    end
    idle_in();
    checks++; if (imem_we !== 1'b1 || err_illegal !== 1'b1) begin errors++; $display("FAIL pre_rst got we %b err %b want 1 1", imem_we, err_illegal); end
    imem_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_wdata !== 32'h0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_rst got we %b wdata %h rdy %b want 0 0 0", imem_we, imem_wdata, in_ready); end
    checks++; if (err_illegal !== 1'b0 || imem_addr !== 10'd0 || word_count !== 10'd0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_st got err %b addr %0d wc %0d done %b want 0 0 0 0", err_illegal, imem_addr, word_count, done); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL post_rst_we%0d got %b want 0", k, imem_we); end
    end
  endtask

  initial begin
    test_reset();
    test_addrr();
    test_andri_cmprr();
    test_program_done();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
